// File: rtl/buzzer_tone_gen.sv
// Piezo driver for the alarm block: resolves channel priority and produces a
// steady tone (ch1), a beeping tone (ch2) or a two-pitch siren (ch3).
module buzzer_tone_gen #(
  parameter int unsigned PRESC  = 4,
  parameter int unsigned HALF1  = 8,
  parameter int unsigned HALF2  = 6,
  parameter int unsigned HALF3A = 4,
  parameter int unsigned HALF3B = 10,
  parameter int unsigned SEG    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] buz_in,
  output logic       tone_out,
  output logic       env_out,
  output logic       active,
  output logic [1:0] chan
);

  localparam int unsigned HMAX12 = (HALF1 > HALF2) ? HALF1 : HALF2;
  localparam int unsigned HMAX3  = (HALF3A > HALF3B) ? HALF3A : HALF3B;
  localparam int unsigned HMAX   = (HMAX12 > HMAX3) ? HMAX12 : HMAX3;
  localparam int unsigned PW     = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned HW     = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int unsigned SW     = (SEG > 1) ? $clog2(SEG) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TONE1  = 2'd1;
  localparam logic [1:0] BEEP2  = 2'd2;
  localparam logic [1:0] SIREN3 = 2'd3;

  logic [2:0]    buz_q;
  logic [PW-1:0] presc_cnt, presc_nxt;
  logic [HW-1:0] half_cnt, half_nxt, half_lim;
  logic [SW-1:0] seg_cnt, seg_cnt_nxt;
  logic          seg, seg_nxt;
  logic          tone_q, tone_nxt;
  logic          env_q, env_nxt;
  logic [1:0]    sel, chan_nxt;
  logic          tick, seg_wrap;

  // Priority select, active half-period limit and next-state logic
  always_comb begin
    sel         = IDLE;
    half_lim    = '0;
    chan_nxt    = chan;
    presc_nxt   = presc_cnt;
    half_nxt    = half_cnt;
    seg_cnt_nxt = seg_cnt;
    seg_nxt     = seg;
    tone_nxt    = tone_q;
    env_nxt     = env_q;

    if (buz_q[2])      sel = SIREN3;
    else if (buz_q[1]) sel = BEEP2;
    else if (buz_q[0]) sel = TONE1;

    case (chan)
      TONE1:   half_lim = HW'(HALF1 - 1);
      BEEP2:   half_lim = HW'(HALF2 - 1);
      SIREN3:  half_lim = seg ? HW'(HALF3B - 1) : HW'(HALF3A - 1);
      default: half_lim = '0;
    endcase

    tick     = (presc_cnt == PW'(PRESC - 1)) && (chan != IDLE);
    seg_wrap = (seg_cnt == SW'(SEG - 1));

    if (sel != chan) begin
      // Channel change: full restart, envelope opens at once for any active channel
      chan_nxt    = sel;
      presc_nxt   = '0;
      half_nxt    = '0;
      seg_cnt_nxt = '0;
      seg_nxt     = 1'b0;
      tone_nxt    = 1'b0;
      env_nxt     = (sel != IDLE);
    end else if (chan != IDLE) begin
      presc_nxt = tick ? '0 : PW'(presc_cnt + 1'b1);
      if (tick) begin
        if (half_cnt == half_lim) begin
          half_nxt = '0;
          tone_nxt = ~tone_q;
        end else begin
          half_nxt = HW'(half_cnt + 1'b1);
        end
        if (seg_wrap) begin
          seg_cnt_nxt = '0;
          seg_nxt     = ~seg;
          // Pitch swap restarts the half period without an extra tone edge
          if (chan == SIREN3) begin
            half_nxt = '0;
            tone_nxt = tone_q;
          end
        end else begin
          seg_cnt_nxt = SW'(seg_cnt + 1'b1);
        end
      end
      env_nxt = (chan == BEEP2) ? ~seg_nxt : 1'b1;
    end else begin
      env_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buz_q     <= '0;
      chan      <= IDLE;
      presc_cnt <= '0;
      half_cnt  <= '0;
      seg_cnt   <= '0;
      seg       <= 1'b0;
      tone_q    <= 1'b0;
      env_q     <= 1'b0;
    end else if (ena) begin
      buz_q     <= buz_in;
      chan      <= chan_nxt;
      presc_cnt <= presc_nxt;
      half_cnt  <= half_nxt;
      seg_cnt   <= seg_cnt_nxt;
      seg       <= seg_nxt;
      tone_q    <= tone_nxt;
      env_q     <= env_nxt;
    end
  end

  assign tone_out = tone_q & env_q;
  assign env_out  = env_q;
  assign active   = (chan != IDLE);

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen with default parameters: vector table
// for tone/beep/siren/priority timing plus hand-written ena and reset sequences.
module tb_buzzer_tone_gen;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] buz_in;
  logic       tone_out;
  logic       env_out;
  logic       active;
  logic [1:0] chan;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] buz;
    int         n;
    logic       tone;
    logic       env;
    logic       act;
    logic [1:0] ch;
  } vec_t;

  vec_t vq[$];

  buzzer_tone_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .buz_in   (buz_in),
    .tone_out (tone_out),
    .env_out  (env_out),
    .active   (active),
    .chan     (chan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic t, input logic e,
                       input logic a, input logic [1:0] c);
    checks++;
    if ({tone_out, env_out, active, chan} !== {t, e, a, c}) begin
      errors++;
      $display("FAIL %s: got tone=%b env=%b active=%b chan=%0d, want tone=%b env=%b active=%b chan=%0d",
               nm, tone_out, env_out, active, chan, t, e, a, c);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [2:0] b, input int n, input logic t,
                     input logic e, input logic a, input logic [1:0] c);
    vec_t v;
    v.buz = b; v.n = n; v.tone = t; v.env = e; v.act = a; v.ch = c;
    vq.push_back(v);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    buz_in = 3'b000;

    // TONE1: E0 then switch S; rises S+32, 64-cycle period for 5 periods
    add(3'b001,  1, 0, 0, 0, 0);
    add(3'b001,  1, 0, 1, 1, 1);
    add(3'b001, 31, 0, 1, 1, 1);
    add(3'b001,  1, 1, 1, 1, 1);
    add(3'b001, 31, 1, 1, 1, 1);
    add(3'b001,  1, 0, 1, 1, 1);
    add(3'b001, 32, 1, 1, 1, 1);
    add(3'b001, 32, 0, 1, 1, 1);
    add(3'b001, 31, 0, 1, 1, 1);
    add(3'b001,  1, 1, 1, 1, 1);
    add(3'b001, 32, 0, 1, 1, 1);
    add(3'b001, 32, 1, 1, 1, 1);
    add(3'b001, 32, 0, 1, 1, 1);
    add(3'b001, 32, 1, 1, 1, 1);
    add(3'b001, 32, 0, 1, 1, 1);
    // Release
    add(3'b000,  1, 0, 1, 1, 1);
    add(3'b000,  1, 0, 0, 0, 0);
    // BEEP2: 24-cycle half period, envelope off S+64..S+128
    add(3'b010,  1, 0, 0, 0, 0);
    add(3'b010,  1, 0, 1, 1, 2);
    add(3'b010, 23, 0, 1, 1, 2);
    add(3'b010,  1, 1, 1, 1, 2);
    add(3'b010, 24, 0, 1, 1, 2);
    add(3'b010, 15, 0, 1, 1, 2);
    add(3'b010,  1, 0, 0, 1, 2);
    add(3'b010,  8, 0, 0, 1, 2);
    add(3'b010, 55, 0, 0, 1, 2);
    add(3'b010,  1, 1, 1, 1, 2);
    add(3'b010, 16, 0, 1, 1, 2);
    // Priority: 011 keeps ch2, then 111 preempts to ch3 with tone cleared
    add(3'b011,  2, 0, 1, 1, 2);
    add(3'b011, 24, 1, 1, 1, 2);
    add(3'b111,  1, 1, 1, 1, 2);
    add(3'b111,  1, 0, 1, 1, 3);
    // SIREN3: 16-cycle halves, swap at 64 (no edge), 40-cycle halves, swap at 128
    add(3'b111, 15, 0, 1, 1, 3);
    add(3'b111,  1, 1, 1, 1, 3);
    add(3'b111, 16, 0, 1, 1, 3);
    add(3'b111, 16, 1, 1, 1, 3);
    add(3'b111, 16, 1, 1, 1, 3);
    add(3'b111, 39, 1, 1, 1, 3);
    add(3'b111,  1, 0, 1, 1, 3);
    add(3'b111, 24, 0, 1, 1, 3);
    add(3'b111, 15, 0, 1, 1, 3);
    add(3'b111,  1, 1, 1, 1, 3);
    // Drop bit2: ch2 restarts from zero
    add(3'b011,  1, 1, 1, 1, 3);
    add(3'b011,  1, 0, 1, 1, 2);
    add(3'b011, 23, 0, 1, 1, 2);
    add(3'b011,  1, 1, 1, 1, 2);
    add(3'b000,  1, 1, 1, 1, 2);
    add(3'b000,  1, 0, 0, 0, 0);

    @(negedge clk);
    check("reset_init", 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("idle_after_reset", 0, 0, 0, 0);

    foreach (vq[i]) begin
      buz_in = vq[i].buz;
      step(vq[i].n);
      check($sformatf("vec%0d", i), vq[i].tone, vq[i].env, vq[i].act, vq[i].ch);
    end

    // ena hold at half_cnt=5 in TONE1: toggle moves from S+32 to S+52
    buz_in = 3'b001;
    step(2);
    check("hold_switch", 0, 1, 1, 1);
    step(22);
    ena    = 1'b0;
    buz_in = 3'b100;
    step(10);
    check("hold_mid", 0, 1, 1, 1);
    step(10);
    check("hold_end", 0, 1, 1, 1);
    ena    = 1'b1;
    buz_in = 3'b001;
    step(9);
    check("hold_pre_toggle", 0, 1, 1, 1);
    step(1);
    check("hold_toggle", 1, 1, 1, 1);
    buz_in = 3'b000;
    step(2);
    check("hold_release", 0, 0, 0, 0);

    // Async reset mid-siren, then stay idle
    buz_in = 3'b100;
    step(2);
    check("rst_pre_switch", 0, 1, 1, 3);
    step(20);
    check("rst_pre_tone", 1, 1, 1, 3);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 0, 0, 0, 0);
    buz_in = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      check($sformatf("rst_idle%0d", i), 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_tone_gen.md
# buzzer_tone_gen

Downstream driver for the sensor alarm block. It consumes the three one-hot buzzer enables and produces an audible square-wave drive on a single piezo pin, with a distinct pattern per alarm channel: steady tone, beeping tone, or two-pitch siren. Channel priority is resolved here, so the alarm block's outputs connect directly without extra glue.

## Interface

Parameters:
- PRESC, 4: clk cycles per tick (≥1)
- HALF1, 8: channel 1 tone half-period, in ticks (≥1)
- HALF2, 6: channel 2 tone half-period, in ticks (≥1)
- HALF3A, 4: channel 3 high-pitch half-period, in ticks (≥1)
- HALF3B, 10: channel 3 low-pitch half-period, in ticks (≥1)
- SEG, 16: segment length in ticks, used for the channel 2 beep on/off and the channel 3 pitch swap (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; when low, all registers hold
- buz_in  in  3  buzzer enables from the alarm block; bit0 is ch1, bit1 is ch2, bit2 is ch3
- tone_out  out  1  piezo drive; equals tone_q AND env_q, both registered
- env_out  out  1  envelope; 1 while sound is gated on
- active  out  1  1 when chan≠0
- chan  out  2  currently served channel; 0 means idle

## Operation

- Input register: buz_q <= buz_in on every enabled cycle.
- Priority select (combinational from buz_q): sel = 3 if buz_q[2]; else 2 if buz_q[1]; else 1 if buz_q[0]; else 0.
- States (chan register):
  - IDLE (0)
  - TONE1 (1)
  - BEEP2 (2)
  - SIREN3 (3)
- Switch event: when sel≠chan on an enabled cycle:
  - chan <= sel.
  - presc_cnt, half_cnt, seg_cnt, seg and tone_q are all cleared to 0.
  - No other counter activity happens that cycle.
- Prescaler: presc_cnt counts 0..PRESC-1 and wraps. tick = (presc_cnt==PRESC-1) and chan≠0. In IDLE, presc_cnt is held at 0.
- Half-period counter:
  - The active value H is HALF1 in TONE1 and HALF2 in BEEP2.
  - In SIREN3, H is HALF3A when seg=0 and HALF3B when seg=1.
  - On tick: if half_cnt==H-1, then half_cnt <= 0 and tone_q toggles; else half_cnt increments.
- Segment counter:
  - On tick: if seg_cnt==SEG-1, then seg_cnt <= 0 and seg toggles; else seg_cnt increments.
  - In SIREN3, a seg toggle also forces half_cnt <= 0 on that tick, overriding the half-period update; tone_q is unchanged.
- Envelope env_q:
  - 0 in IDLE.
  - 1 in TONE1 and SIREN3.
  - ~seg in BEEP2: sound on during even segments, silent during odd ones.
  - env_q is registered and updates on the same edge as seg and chan.
- Width rules:
  - Counters are sized as $clog2 of their maximum value, with a minimum width of 1.
  - The half_cnt compare uses the currently selected H.
  - No counter ever exceeds its limit-1.
- Simultaneous enables: the higher channel wins. Dropping a higher channel while a lower one is still set causes a switch to the lower channel with a full restart.
- ena low: all state, including buz_q, freezes and outputs hold. Resuming continues exactly where it stopped.
- Reset (async): buz_q=0, chan=0, all counters=0, seg=0, tone_q=0, env_q=0. Therefore tone_out=0, env_out=0, active=0 and chan=0. Reset asserted mid-tone silences the output immediately.

## Timing

- Input-to-switch latency: buz_in is sampled at edge E0; chan updates at edge E0+1.
- First tone edge:
  - From switch edge S, the first tick occurs during the cycle ending at S+PRESC.
  - tone_q first rises at S+PRESC·H.
  - Full period is 2·PRESC·H cycles (TONE1 defaults: 32 cycles to first rise, 64-cycle period).
- env_q rises at S (the switch edge) for TONE1, SIREN3 and BEEP2.
- BEEP2 envelope:
  - Falls after SEG ticks (S+PRESC·SEG = S+64).
  - Rises again after 2·SEG ticks.
- SIREN3 pitch swap every PRESC·SEG = 64 cycles; half_cnt restarts at each swap.
- Release: buz_in cleared before edge E0 gives chan=0, env_q=0 and tone_q=0 at E0+1, so tone_out is 0 from E0+1.

## Test plan

- Reset: assert rst_n=0 mid-operation with ch3 active → tone_out, env_out, active and chan are 0 asynchronously; after release with buz_in=0, everything stays 0 for 200 cycles.
- TONE1 (defaults): buz_in=001 sampled at E0 → chan=1 at E0+1; tone_out rises at E0+33 and falls at E0+65; 64-cycle period for 5 periods.
- BEEP2: buz_in=010 → env_out=1 from switch S to S+64, 0 from S+64 to S+128; tone_out toggles every 24 cycles while the envelope is on and is stuck at 0 while it is off.
- SIREN3: buz_in=100 → half-period of 16 cycles for 64 cycles, then 40 cycles for the next 64 (half_cnt cleared at the swap), repeating; env_out stays 1.
- Priority and preemption: buz_in=011 → chan=2. Then set 111 → chan=3 with counters cleared and tone_out=0 on the switch edge. Then clear bit2 → chan=2 restarted from zero.
- ena hold: in TONE1 at half_cnt=5, drop ena for 20 cycles → no change on any output. On resume, the next toggle occurs exactly 20 cycles later than without the pause.
